// File: rtl/vc_shadow_commit_reg_bank.sv
// ----------------------------------------------------------------------------
// vc_shadow_commit_reg_bank
//
// Multi-channel shadow/active register bank for clock-divider and PLL
// configuration words. Software-side writes land in a per-channel shadow
// word at any time; the active words (q) only take the shadow contents on a
// commit, and a commit only happens in a cycle where the divider reports a
// safe boundary (commit_safe). This lets ratio/phase changes take effect
// glitch-free on a divided-clock edge.
//
// Ports
//   clk          clock, all state updates on posedge
//   reset        asynchronous, active-high reset
//   wr_en        per-channel shadow write enable
//   wr_data      shadow write data, channel i at [i*p_nbits +: p_nbits]
//   clr          synchronous clear of every shadow word to p_reset_value
//   commit_req   commit request (pulse or level)
//   commit_safe  divider boundary strobe; commits happen only when high
//   pending      commit armed and waiting for commit_safe
//   commit_done  one-cycle pulse the cycle after each commit edge
//   dirty        per-channel "shadow changed since last commit"
//   shadow_q     current shadow words
//   q            active words driven to the divider
// ----------------------------------------------------------------------------
module vc_shadow_commit_reg_bank #(
  parameter int p_nbits       = 8,
  parameter int p_nchan       = 4,
  parameter int p_reset_value = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [p_nchan-1:0]         wr_en,
  input  logic [p_nchan*p_nbits-1:0] wr_data,
  input  logic                       clr,
  input  logic                       commit_req,
  input  logic                       commit_safe,
  output logic                       pending,
  output logic                       commit_done,
  output logic [p_nchan-1:0]         dirty,
  output logic [p_nchan*p_nbits-1:0] shadow_q,
  output logic [p_nchan*p_nbits-1:0] q
);

  // Reset/clear word, truncated to the channel width.
  localparam logic [p_nbits-1:0] lp_rst_word = p_nbits'(p_reset_value);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ARMED = 1'b1
  } state_t;

  state_t                       state_q, state_d;
  logic [p_nchan*p_nbits-1:0]   shadow_d, shadow_r;
  logic [p_nchan*p_nbits-1:0]   active_d, active_q;
  logic [p_nchan-1:0]           dirty_d, dirty_q;
  logic                         done_d, done_q;
  logic                         commit;

  // --------------------------------------------------------------------------
  // Commit handshake FSM. A request that arrives together with commit_safe
  // commits immediately without visiting ARMED; requests seen while ARMED
  // are absorbed (there is no queue of commits).
  // --------------------------------------------------------------------------
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    state_d = state_q;
    commit  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (commit_req) begin
          if (commit_safe) commit  = 1'b1;
          else             state_d = ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (commit_safe) begin
          commit  = 1'b1;
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Per-channel datapath. The active words capture the pre-edge shadow, so a
  // write colliding with a commit leaves its new value dirty for the next one.
  // --------------------------------------------------------------------------
  always_comb begin
    shadow_d = shadow_r;
    dirty_d  = dirty_q;
    active_d = commit ? shadow_r : active_q;
    done_d   = commit;
    for (int i = 0; i < p_nchan; i++) begin
      if (wr_en[i]) begin
        shadow_d[i*p_nbits +: p_nbits] = wr_data[i*p_nbits +: p_nbits];
        dirty_d[i]                     = 1'b1;
      end else if (clr) begin
        shadow_d[i*p_nbits +: p_nbits] = lp_rst_word;
        dirty_d[i]                     = 1'b1;
      end else if (commit) begin
        dirty_d[i]                     = 1'b0;
      end
    end
  end

  // NOTE: every register here is reset, including the word arrays; the
  // active words feed the divider directly and must never come up unknown.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      shadow_r <= {p_nchan{lp_rst_word}};
      active_q <= {p_nchan{lp_rst_word}};
      dirty_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values regardless of statement order.
      state_q  <= state_d;
      shadow_r <= shadow_d;
      active_q <= active_d;
      dirty_q  <= dirty_d;
      done_q   <= done_d;
    end
  end

  assign pending     = (state_q == ST_ARMED);
  assign commit_done = done_q;
  assign dirty       = dirty_q;
  assign shadow_q    = shadow_r;
  assign q           = active_q;

endmodule

// File: tb/tb_vc_shadow_commit_reg_bank.sv
// ----------------------------------------------------------------------------
// Testbench for vc_shadow_commit_reg_bank (8-bit words, 4 channels, reset 0).
// Directed table of vectors, hand-written reset sequences, then randomized
// traffic compared against a word-array reference model.
// ----------------------------------------------------------------------------
module tb_vc_shadow_commit_reg_bank;

  localparam int NB = 8;
  localparam int NC = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [NC-1:0]     wr_en;
  logic [NC*NB-1:0]  wr_data;
  logic              clr;
  logic              commit_req;
  logic              commit_safe;
  logic              pending;
  logic              commit_done;
  logic [NC-1:0]     dirty;
  logic [NC*NB-1:0]  shadow_q;
  logic [NC*NB-1:0]  q;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vc_shadow_commit_reg_bank #(
    .p_nbits(NB), .p_nchan(NC), .p_reset_value(0)
  ) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .clr(clr),
    .commit_req(commit_req), .commit_safe(commit_safe), .pending(pending),
    .commit_done(commit_done), .dirty(dirty), .shadow_q(shadow_q), .q(q)
  );

  // ---------------------------------------------------------------- checking
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_in(input logic [NC-1:0] we, input logic [NC*NB-1:0] wd,
                        input logic c, input logic req, input logic safe);
    wr_en = we; wr_data = wd; clr = c; commit_req = req; commit_safe = safe;
  endtask

  // One clock: inputs already applied, sample outputs 1 time unit after edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------- reference model
  logic [NB-1:0] m_sh  [NC];
  logic [NB-1:0] m_act [NC];
  logic [NC-1:0] m_dirty;
  bit            m_armed;
  bit            m_done;

  function automatic void model_reset();
    for (int i = 0; i < NC; i++) begin m_sh[i] = '0; m_act[i] = '0; end
    m_dirty = '0; m_armed = 0; m_done = 0;
  endfunction

  // Applies the rules for one rising edge using the current inputs.
  function automatic void model_edge();
    bit fire;
    fire   = commit_safe && (m_armed || commit_req);
    m_done = fire;
    if (fire)
      for (int i = 0; i < NC; i++) m_act[i] = m_sh[i];
    for (int i = 0; i < NC; i++) begin
      if (wr_en[i]) begin
        m_sh[i] = wr_data[i*NB +: NB]; m_dirty[i] = 1'b1;
      end else if (clr) begin
        m_sh[i] = '0; m_dirty[i] = 1'b1;
      end else if (fire) begin
        m_dirty[i] = 1'b0;
      end
    end
    m_armed = fire ? 0 : (m_armed || commit_req);
  endfunction

  function automatic logic [NC*NB-1:0] pack(input logic [NB-1:0] w [NC]);
    logic [NC*NB-1:0] r;
    for (int i = 0; i < NC; i++) r[i*NB +: NB] = w[i];
    return r;
  endfunction

  // ---------------------------------------------------------- directed table
  typedef struct {
    logic [NC-1:0]    we;
    logic [NC*NB-1:0] wd;
    logic             c;
    logic             req;
    logic             safe;
    logic [NC*NB-1:0] e_q;
    logic [NC*NB-1:0] e_sh;
    logic [NC-1:0]    e_dirty;
    logic             e_pend;
    logic             e_done;
  } vec_t;

  vec_t vecs[15];

  initial begin
    // Armed commit: write ch0=5A, ch2=C3, request without safe, wait, commit.
    vecs[0]  = '{4'b0101, 32'h00C3_005A, 0, 0, 0, 32'h0,         32'h00C3_005A, 4'b0101, 0, 0};
    vecs[1]  = '{4'b0000, 32'h0,         0, 1, 0, 32'h0,         32'h00C3_005A, 4'b0101, 1, 0};
    vecs[2]  = '{4'b0000, 32'h0,         0, 0, 0, 32'h0,         32'h00C3_005A, 4'b0101, 1, 0};
    vecs[3]  = '{4'b0000, 32'h0,         0, 1, 0, 32'h0,         32'h00C3_005A, 4'b0101, 1, 0};
    vecs[4]  = '{4'b0000, 32'h0,         0, 0, 0, 32'h0,         32'h00C3_005A, 4'b0101, 1, 0};
    vecs[5]  = '{4'b0000, 32'h0,         0, 0, 0, 32'h0,         32'h00C3_005A, 4'b0101, 1, 0};
    vecs[6]  = '{4'b0000, 32'h0,         0, 0, 1, 32'h00C3_005A, 32'h00C3_005A, 4'b0000, 0, 1};
    vecs[7]  = '{4'b0000, 32'h0,         0, 0, 0, 32'h00C3_005A, 32'h00C3_005A, 4'b0000, 0, 0};
    // Write collides with a zero-wait commit, then back-to-back commit.
    vecs[8]  = '{4'b0010, 32'h0000_1000, 0, 0, 0, 32'h00C3_005A, 32'h00C3_105A, 4'b0010, 0, 0};
    vecs[9]  = '{4'b0010, 32'h0000_2000, 0, 1, 1, 32'h00C3_105A, 32'h00C3_205A, 4'b0010, 0, 1};
    vecs[10] = '{4'b0000, 32'h0,         0, 1, 1, 32'h00C3_205A, 32'h00C3_205A, 4'b0000, 0, 1};
    vecs[11] = '{4'b0000, 32'h0,         0, 0, 0, 32'h00C3_205A, 32'h00C3_205A, 4'b0000, 0, 0};
    // Clear and write together; safe alone does nothing; then arm.
    vecs[12] = '{4'b0010, 32'h0000_7F00, 1, 0, 0, 32'h00C3_205A, 32'h0000_7F00, 4'b1111, 0, 0};
    vecs[13] = '{4'b0000, 32'h0,         0, 0, 1, 32'h00C3_205A, 32'h0000_7F00, 4'b1111, 0, 0};
    vecs[14] = '{4'b0000, 32'h0,         0, 1, 0, 32'h00C3_205A, 32'h0000_7F00, 4'b1111, 1, 0};
  end

  task automatic check_all_zero(input string tag);
    check({tag, ".q"},        64'(q),           64'h0);
    check({tag, ".shadow"},   64'(shadow_q),    64'h0);
    check({tag, ".pending"},  64'(pending),     64'h0);
    check({tag, ".done"},     64'(commit_done), 64'h0);
    check({tag, ".dirty"},    64'(dirty),       64'h0);
  endtask

  // ------------------------------------------------------------------ main
  initial begin
    reset = 1'b1;
    set_in('0, '0, 0, 0, 0);
    #12;
    check_all_zero("por");
    @(negedge clk);
    reset = 1'b0;
    #4;  // next inputs are applied away from posedge

    // Load q = 44/33/22/11, then assert reset between edges.
    set_in(4'b1111, 32'h4433_2211, 0, 0, 0); tick();
    set_in('0, '0, 0, 1, 1);                 tick();
    set_in('0, '0, 0, 0, 0);
    check("load.q",    64'(q),           64'h4433_2211);
    check("load.done", 64'(commit_done), 64'h1);
    #3 reset = 1'b1;
    #1 check_all_zero("async_rst");
    #2 reset = 1'b0;

    // Directed table.
    foreach (vecs[k]) begin
      set_in(vecs[k].we, vecs[k].wd, vecs[k].c, vecs[k].req, vecs[k].safe);
      tick();
      check($sformatf("vec%0d.q", k),       64'(q),           64'(vecs[k].e_q));
      check($sformatf("vec%0d.shadow", k),  64'(shadow_q),    64'(vecs[k].e_sh));
      check($sformatf("vec%0d.dirty", k),   64'(dirty),       64'(vecs[k].e_dirty));
      check($sformatf("vec%0d.pending", k), 64'(pending),     64'(vecs[k].e_pend));
      check($sformatf("vec%0d.done", k),    64'(commit_done), 64'(vecs[k].e_done));
    end

    // Reset while ARMED with all channels dirty, then safe without request.
    set_in('0, '0, 0, 0, 0);
    #3 reset = 1'b1;
    #1 check_all_zero("mid_hs_rst");
    #2 reset = 1'b0;
    set_in('0, '0, 0, 0, 1); tick();
    check("post_rst.q",       64'(q),           64'h0);
    check("post_rst.done",    64'(commit_done), 64'h0);
    check("post_rst.pending", 64'(pending),     64'h0);
    set_in('0, '0, 0, 0, 0); tick();
    check("post_rst2.done",   64'(commit_done), 64'h0);

    // Randomized traffic against the model, with occasional async resets.
    model_reset();
    for (int n = 0; n < 600; n++) begin
      set_in(4'($urandom_range(0, 3) == 0 ? $urandom : 0), 32'($urandom),
             ($urandom_range(0, 9) == 0), ($urandom_range(0, 3) == 0),
             ($urandom_range(0, 2) == 0));
      if ($urandom_range(0, 149) == 0) begin
        #3 reset = 1'b1;
        model_reset();
        #1 reset = 1'b0;
      end
      model_edge();
      tick();
      check("rnd.q",       64'(q),           64'(pack(m_act)));
      check("rnd.shadow",  64'(shadow_q),    64'(pack(m_sh)));
      check("rnd.dirty",   64'(dirty),       64'(m_dirty));
      check("rnd.pending", 64'(pending),     64'(m_armed));
      check("rnd.done",    64'(commit_done), 64'(m_done));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vc_shadow_commit_reg_bank.md
Name: vc_shadow_commit_reg_bank

Overview:
- Parametrised multi-channel enable register bank with asynchronous reset.
- Each channel has a shadow stage, written at any time, and an active stage, updated only on a commit handshake.
- The commit lands on a divider-supplied safe boundary strobe.
- Used to hold clock-divider/PLL configuration words (divide ratios, phase offsets) so that ratio changes take effect glitch-free on a divided-clock edge.

Parameters:
- p_nbits, 8, width of one channel word.
- p_nchan, 4, number of channels (>=1).
- p_reset_value, 0, value loaded into every shadow and active word on reset and clear (truncated to p_nbits).

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  asynchronous, active-high reset.
- wr_en  input  p_nchan  per-channel shadow write enable.
- wr_data  input  p_nchan*p_nbits  shadow write data; channel i occupies bits [i*p_nbits +: p_nbits].
- clr  input  1  synchronous clear of all shadow words to p_reset_value.
- commit_req  input  1  request to transfer shadow to active; single-cycle pulse or level.
- commit_safe  input  1  boundary strobe from the divider; a commit may occur only in a cycle where this is 1.
- pending  output  1  commit armed, waiting for commit_safe.
- commit_done  output  1  one-cycle pulse, the cycle after a commit edge.
- dirty  output  p_nchan  channel shadow changed since the last commit.
- shadow_q  output  p_nchan*p_nbits  current shadow words.
- q  output  p_nchan*p_nbits  active words; the values driven to the divider.

Behaviour:
- Reset (async, any time, including mid-handshake):
  - shadow_q = q = p_reset_value on every channel.
  - dirty = 0, pending = 0, commit_done = 0, FSM = IDLE.
  - Takes effect immediately, without waiting for clk.
- Shadow update per channel i on posedge, priority order:
  - wr_en[i]=1: shadow[i] <= wr_data[i], dirty[i] <= 1.
  - else clr=1: shadow[i] <= p_reset_value, dirty[i] <= 1.
  - else: hold.
- FSM states: IDLE, ARMED. pending = (state == ARMED).
  - IDLE, commit_req=1, commit_safe=0 -> ARMED.
  - IDLE, commit_req=1, commit_safe=1 -> commit on this edge, stay IDLE (zero-wait commit).
  - IDLE, commit_req=0 -> IDLE; commit_safe alone has no effect.
  - ARMED, commit_safe=1 -> commit on this edge, -> IDLE.
  - ARMED, commit_safe=0 -> ARMED. Further commit_req pulses are absorbed; there is no queue.
- Commit edge:
  - q[i] <= shadow[i] for every channel, using the pre-edge shadow value.
  - dirty[i] <= 0, unless wr_en[i] or clr is also active in the same cycle, in which case dirty[i] <= 1 and the new shadow value waits for the next commit.
  - commit_done = 1 for exactly the following cycle.
- Active words change only on commit edges; q never changes in a cycle without commit_safe=1.
- Back-to-back commits: commit_req=1 and commit_safe=1 held continuously produce a commit every cycle, with commit_done high continuously (one pulse per commit).
- Widths:
  - Reset value truncated to p_nbits.
  - No arithmetic; all channels independent except the shared clr and commit.
- Latency:
  - Shadow write visible on shadow_q 1 cycle after the wr_en edge.
  - Commit visible on q 1 cycle after the commit edge, with commit_done aligned to q.

Test Plan:
- Reset: assert reset asynchronously between clock edges after loading q=0x11/22/33/44 -> q, shadow_q = 0x00 immediately; pending=0, commit_done=0, dirty=0000.
- Armed commit: write ch0=0x5A, ch2=0xC3; pulse commit_req with commit_safe=0 for 5 cycles, then commit_safe=1 for 1 cycle:
  - Before the commit: pending=1, dirty=0101, q unchanged.
  - Cycle after the commit: q ch0=0x5A, ch2=0xC3, commit_done=1, pending=0, dirty=0000.
- Zero-wait commit: commit_req=1 and commit_safe=1 in the same cycle from IDLE -> q updated next cycle, pending never asserted, single commit_done pulse.
- Write collides with commit: shadow ch1=0x10; commit edge with wr_en[1]=1, wr_data ch1=0x20 -> q ch1=0x10, shadow ch1=0x20, dirty[1]=1; next commit -> q ch1=0x20.
- Clear and write together: clr=1 with wr_en=0010, data 0x7F -> shadow ch1=0x7F, other channels 0x00, dirty=1111, q unchanged until commit.
- Reset mid-handshake: ARMED with dirty=1111, assert reset -> pending=0; a later commit_safe=1 without commit_req leaves q=0x00 and produces no commit_done.
